// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide engine: shift-add multiply and restoring divide,
// one bit per cycle, with MTHI/MTLO writes and a start/busy/done handshake.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned W  = WIDTH;
  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(ITER);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [W-1:0]    m_q, m_d;
  logic [W-1:0]    rem_q, rem_d;
  logic            is_div_q, is_div_d;
  logic            neg_res_q, neg_res_d;
  logic            neg_a_q, neg_a_d;
  logic            bzero_q, bzero_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;

  // Datapath for one iteration and the signed fix-up at FINISH
  logic [W:0]      mul_sum;
  logic [W:0]      rem_shift;
  logic            sub_ok;
  logic [W-1:0]    trial;
  logic [DW-1:0]   prod_fix;
  logic [W-1:0]    quo_fix;
  logic [W-1:0]    rem_fix;
  logic            sgn;
  logic [W-1:0]    a_mag;
  logic [W-1:0]    b_mag;

  assign mul_sum   = {1'b0, acc_q[DW-1:W]} + (acc_q[0] ? {1'b0, m_q} : (W+1)'(0));
  assign rem_shift = {rem_q, acc_q[W-1]};
  assign sub_ok    = rem_shift >= {1'b0, m_q};
  // Difference always fits in W bits when the subtract succeeds
  assign trial     = rem_shift[W-1:0] - m_q;
  assign prod_fix  = neg_res_q ? (~acc_q + DW'(1)) : acc_q;
  assign quo_fix   = neg_res_q ? (~acc_q[W-1:0] + W'(1)) : acc_q[W-1:0];
  assign rem_fix   = neg_a_q ? (~rem_q + W'(1)) : rem_q;
  assign sgn       = op[0];
  assign a_mag     = (sgn && a[W-1]) ? (~a + W'(1)) : a;
  assign b_mag     = (sgn && b[W-1]) ? (~b + W'(1)) : b;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    m_d       = m_q;
    rem_d     = rem_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_a_d   = neg_a_q;
    bzero_d   = bzero_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              is_div_d  = op[1];
              neg_res_d = sgn && (a[W-1] ^ b[W-1]);
              neg_a_d   = sgn && a[W-1];
              bzero_d   = (b == '0);
              rem_d     = '0;
              count_d   = '0;
              busy_d    = 1'b1;
              state_d   = S_RUN;
              if (op[1]) begin
                acc_d = {W'(0), a_mag};
                m_d   = b_mag;
              end else begin
                acc_d = {W'(0), b_mag};
                m_d   = a_mag;
              end
            end
            3'b100:  hi_d = a;
            3'b101:  lo_d = a;
            default: ;
          endcase
        end
      end

      S_RUN: begin
        if (is_div_q) begin
          acc_d[W-1:0] = {acc_q[W-2:0], sub_ok};
          rem_d        = sub_ok ? trial : rem_shift[W-1:0];
        end else begin
          acc_d = {mul_sum, acc_q[W-1:1]};
        end
        count_d = count_q + CW'(1);
        if (count_q == CW'(ITER - 1)) begin
          state_d = S_FINISH;
        end
      end

      S_FINISH: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = bzero_q ? '1 : quo_fix;
        end else begin
          hi_d = prod_fix[DW-1:W];
          lo_d = prod_fix[W-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      m_q       <= '0;
      rem_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_a_q   <= 1'b0;
      bzero_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      m_q       <= m_d;
      rem_q     <= rem_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_a_q   <= neg_a_d;
      bzero_q   <= bzero_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, random ops against
// an arithmetic reference model, and hand sequences for reset/handshake corners.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } vec_t;

  vec_t tbl[$];

  function automatic void check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endfunction

  // Reference: MIPS semantics computed with wide integer arithmetic
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      3'b000: return ux * uy;
      3'b001: return sx * sy;
      3'b010: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        return {32'((ux % uy)), 32'((ux / uy))};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Issue one mul/div, check busy, latency, HI/LO hold, result and done width
  task automatic run_op(input logic [2:0] o, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] ehi, input logic [31:0] elo, input string nm);
    int n;
    logic [31:0] hi0, lo0;
    bit held;
    hi0 = hi; lo0 = lo; held = 1'b1;
    start = 1'b1; op = o; a = ia; b = ib;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    check({nm, " busy_after_start"}, 32'(busy), 32'd1);
    n = 0;
    while (n < 60 && !done) begin
      if (hi !== hi0 || lo !== lo0) held = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    // Busy covers E0..E33; done and results appear after the 33rd edge
    check({nm, " latency"}, 32'(n), 32'd33);
    check({nm, " busy_end"}, 32'(busy), 32'd0);
    check({nm, " hilo_hold"}, 32'(held), 32'd1);
    check({nm, " hi"}, hi, ehi);
    check({nm, " lo"}, lo, elo);
    @(posedge clk); #1;
    check({nm, " done_one_cycle"}, 32'(done), 32'd0);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 60 && !done) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nd;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    logic [63:0] exp;

    tbl.push_back('{3'b001, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, "mult_neg"});
    tbl.push_back('{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"});
    tbl.push_back('{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minmin"});
    tbl.push_back('{3'b011, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg"});
    tbl.push_back('{3'b010, 32'd7,        32'd2,        32'd1,        32'd3,        "divu_7_2"});
    tbl.push_back('{3'b010, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, "divu_by0"});
    tbl.push_back('{3'b011, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, "div_neg_by0"});
    tbl.push_back('{3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf"});

    reset = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset mid-run: make HI nonzero first so the clear is observable
    start = 1'b1; op = 3'b100; a = 32'h0000DEAD;
    @(posedge clk); #1;
    start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_hi", hi, 32'd0);
    check("async_reset_lo", lo, 32'd0);
    check("async_reset_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      nd += int'(done);
    end
    check("no_done_after_reset", 32'(nd), 32'd0);
    run_op(3'b000, 32'd3, 32'd5, 32'd0, 32'd15, "multu_3_5");

    foreach (tbl[i]) run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].name);

    // MTHI then MTLO back to back: immediate writes, no handshake
    start = 1'b1; op = 3'b100; a = 32'hCAFEF00D;
    @(posedge clk); #1;
    check("mthi_hi", hi, 32'hCAFEF00D);
    check("mthi_busy", 32'(busy), 32'd0);
    op = 3'b101; a = 32'h0BADBEEF;
    @(posedge clk); #1;
    start = 1'b0;
    check("mtlo_lo", lo, 32'h0BADBEEF);
    check("mtlo_hi_kept", hi, 32'hCAFEF00D);
    check("mtlo_busy", 32'(busy), 32'd0);
    check("mtlo_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("mt_done_after", 32'(done), 32'd0);

    // Reserved op is ignored
    start = 1'b1; op = 3'b110; a = 32'h11111111;
    @(posedge clk); #1;
    start = 1'b0;
    check("rsvd_busy", 32'(busy), 32'd0);
    check("rsvd_hi", hi, 32'hCAFEF00D);
    check("rsvd_lo", lo, 32'h0BADBEEF);

    // Start while busy is dropped; start in the done cycle is taken
    start = 1'b1; op = 3'b000; a = 32'd2; b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op = 3'b010; a = 32'd9; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    check("busy_start_latency", 32'(n), 32'd28);
    check("busy_start_lo", lo, 32'd4);
    check("busy_start_hi", hi, 32'd0);
    start = 1'b1; op = 3'b010; a = 32'd9; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_cycle_accept_busy", 32'(busy), 32'd1);
    wait_done(n);
    check("done_cycle_latency", 32'(n), 32'd33);
    check("done_cycle_lo", lo, 32'd3);
    check("done_cycle_hi", hi, 32'd0);
    @(posedge clk); #1;

    // Random mul/div against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'h80000000;
        3: rb = 32'hFFFFFFFF;
        default: ;
      endcase
      exp = model(ro, ra, rb);
      run_op(ro, ra, rb, exp[63:32], exp[31:0], $sformatf("rand%0d_op%0d", i, ro));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
